// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to 4-digit seven-segment display with sign/overflow LEDs
//
// Accepts one ALU result word per valid/ready handshake, interprets it as a
// signed value (6-bit for add/sub/div, 12-bit for mul), converts the
// magnitude to BCD with a 12-step shift-add-3 engine and scans the result
// onto a multiplexed 4-digit display with leading-zero blanking.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   c_in        in   [11:0] ALU result word
//   op_in       in   [1:0]  opcode: 00 add, 01 sub, 10 mul, 11 div
//   overflow_in in   ALU overflow flag for this word
//   valid_in    in   word valid
//   ready_out   out  idle, able to accept a word
//   seg_out     out  [6:0] segments {g,f,e,d,c,b,a}, active-high
//   dig_out     out  [3:0] one-hot digit enable, bit0 = units
//   sign_out    out  displayed value is negative
//   ovf_out     out  overflow of the displayed result
module alu_result_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] c_in,
  input  logic [1:0]  op_in,
  input  logic        overflow_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [6:0]  seg_out,
  output logic [3:0]  dig_out,
  output logic        sign_out,
  output logic        ovf_out
);

  localparam int CW = SCAN_DIV + 2;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;

  state_t      state, state_nx;
  logic [11:0] c_q;
  logic [1:0]  op_q;
  logic        ovf_q;
  logic        sign_q;
  logic [11:0] mag;
  logic [15:0] bcd;
  logic [3:0]  iter;
  logic [15:0] disp;
  logic [CW-1:0] scan_cnt;

  logic [11:0] value;
  logic [15:0] bcd_adj;
  logic [15:0] disp_nx;
  logic [CW-1:0] scan_nx;
  logic [1:0]  idx_nx;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = 7'b0000000;
    endcase
  endfunction

  // Multiply results use the full word; the other ops only produce 6 bits.
  assign value = (op_q == 2'b10) ? c_q : {{6{c_q[5]}}, c_q[5:0]};

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_in) state_nx = LOAD;
      LOAD:    state_nx = CONV;
      CONV:    if (iter == 4'd11) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign ready_out = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q      <= '0;
      op_q     <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      iter     <= '0;
      disp     <= '0;
      sign_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          c_q   <= c_in;
          op_q  <= op_in;
          ovf_q <= overflow_in;
        end
        LOAD: begin
          sign_q <= value[11];
          // Two's-complement negate; -2048 stays 0x800 which reads as 2048.
          mag    <= value[11] ? (~value + 12'd1) : value;
          bcd    <= '0;
          iter   <= '0;
        end
        CONV: begin
          {bcd, mag} <= {bcd_adj[14:0], mag, 1'b0};
          iter       <= iter + 4'd1;
        end
        COMMIT: begin
          disp     <= bcd;
          sign_out <= sign_q;
          ovf_out  <= ovf_q;
        end
        default: ;
      endcase
    end
  end

  // seg_out is registered from next-cycle values so it stays aligned with
  // dig_out (decoded straight from the counter) and with the COMMIT update.
  assign disp_nx = (state == COMMIT) ? bcd : disp;
  assign scan_nx = scan_cnt + 1'b1;
  assign idx_nx  = scan_nx[CW-1 -: 2];

  always_comb begin
    nib   = disp_nx[3:0];
    blank = 1'b0;
    case (idx_nx)
      2'd0: begin nib = disp_nx[3:0];   blank = 1'b0;                   end
      2'd1: begin nib = disp_nx[7:4];   blank = (disp_nx[15:4] == '0);  end
      2'd2: begin nib = disp_nx[11:8];  blank = (disp_nx[15:8] == '0);  end
      2'd3: begin nib = disp_nx[15:12]; blank = (disp_nx[15:12] == '0); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      seg_out  <= 7'b0111111;
    end else begin
      scan_cnt <= scan_nx;
      seg_out  <= blank ? 7'b0000000 : seg_encode(nib);
    end
  end

  assign dig_out = 4'b0001 << scan_cnt[CW-1 -: 2];

endmodule
